gb_cpu_mcycle_sequencer: RTL and testbench
==========================================

# gb_cpu_mcycle_sequencer

Sequential companion to the combinational `gb_cpu_decoder`. It holds the current opcode and CB-prefix state, and steps T-cycle and M-cycle counters through each instruction's schedule length. It also handles conditional early termination, HALT, and interrupt-dispatch pseudo-instructions. It sits between the memory data bus and the decoder, and its counters index the decoder's `schedule_t`.

## Interface
- `MAX_MCYCLES`, default 6: longest schedule in M-cycles; counter width is `$clog2(MAX_MCYCLES)`.
- `TCYCLES_PER_M`, default 4: T-cycles per M-cycle.
- `ISR_MCYCLES`, default 5: length of the interrupt-dispatch pseudo-instruction.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `tick_en` input, 1 bit: T-cycle advance enable; when low, all state holds.
- `data_i` input, 8 bits: data bus, sampled as the next opcode at fetch.
- `sched_len_i` input, `CNT_W+1` bits: decoder M-cycle count, condition taken or unconditional.
- `sched_len_nt_i` input, `CNT_W+1` bits: decoder M-cycle count, condition not taken.
- `cond_i` input, 1 bit: the opcode is conditional.
- `cond_taken_i` input, 1 bit: flag test result, valid in M-cycle 1.
- `irq_i` input, 1 bit: any enabled interrupt is pending.
- `ime_i` input, 1 bit: interrupt master enable.
- `opcode_o` output, 8 bits: current opcode; drives the decoder.
- `cb_prefix_o` output, 1 bit: current opcode is from the CB table.
- `mcycle_o` output, `CNT_W` bits: current M-cycle index.
- `tcycle_o` output, `$clog2(TCYCLES_PER_M)` bits: current T-cycle index.
- `last_mcycle_o` output, 1 bit: current M-cycle ends the instruction.
- `isr_o` output, 1 bit: an interrupt dispatch is in progress.
- `halted_o` output, 1 bit: the core is in HALT.
- `irq_ack_o` output, 1 bit: one-`tick_en` pulse acknowledging the interrupt.

## Operation
- States: `EXEC`, `ISR`, `HALT`.
- Reset values:
  - State is `EXEC`.
  - `opcode_o`=8'h00, `cb_prefix_o`=0, `mcycle_o`=0, `tcycle_o`=0.
  - All other outputs are 0.
  - The core therefore executes a 1-M-cycle NOP whose final M-cycle fetches the first opcode.
- Effective length L:
  - L = `sched_len_nt_i` if `cond_i` && !`cond_taken_i`, else `sched_len_i`.
  - L=0 is treated as 1; L>MAX_MCYCLES is treated as MAX_MCYCLES.
  - In `ISR`, L=ISR_MCYCLES.
- `last_mcycle_o` = (`mcycle_o` == L-1). It is combinational and is 0 in `HALT`.
- `tcycle_o` increments on each `tick_en` and wraps at TCYCLES_PER_M-1.
- On wrap without `last_mcycle_o`, `mcycle_o` increments.
- On wrap with `last_mcycle_o` (instruction end), `mcycle_o`←0 and the following priority applies:
  1. Opcode 8'hCB with `cb_prefix_o`=0: `cb_prefix_o`←1, `opcode_o`←`data_i`. No interrupt check is made here; prefix and suffix are atomic.
  2. `EXEC` with unprefixed opcode 8'h76 and !`irq_i`: go to `HALT`; `opcode_o` is held.
  3. `ime_i` && `irq_i`: go to `ISR`; `opcode_o` and `cb_prefix_o` are held.
  4. Otherwise: `opcode_o`←`data_i`, `cb_prefix_o`←0, state goes to or stays `EXEC`.
- `ISR`:
  - `isr_o`=1.
  - `irq_ack_o` pulses on the `tick_en` at T-cycle wrap of M-cycle 2.
  - At the end of the ISR, rule 4 applies. Interrupts are not re-checked, because IME is cleared by the core.
- `HALT`:
  - `halted_o`=1, `mcycle_o` holds 0, `tcycle_o` keeps counting.
  - At a T-cycle wrap with `irq_i`:
    - if `ime_i`, go to `ISR`;
    - otherwise go to `EXEC` with `opcode_o`←`data_i`.
- The HALT bug and the EI delay are out of scope and belong to the core.

## Timing
- All state is registered on `posedge clk` or `posedge reset`.
- Outputs depend only on registered state, except `last_mcycle_o`, which is combinational from the length inputs.
- Opcode latch latency:
  - `data_i` is sampled on the `tick_en` edge that ends the instruction.
  - The new `opcode_o` is visible from the next cycle.
- Instruction duration is L×TCYCLES_PER_M `tick_en` pulses.
- `cond_taken_i` is consulted from M-cycle 1 onward. A not-taken branch ends after `sched_len_nt_i` M-cycles.
- Simultaneous events:
  - `irq_i` rising in the last M-cycle of a CB prefix is deferred until the suffix ends.
  - With HALT and `irq_i` both present at end of instruction, HALT is not entered.
- `reset` mid-instruction: all state returns to its reset values immediately and asynchronously.
- `tick_en` low: all counters, state and the pulse generator hold; `irq_ack_o` stays 0.

## Structure
- Shared package `gb_cpu_common_pkg` holds:
  - `seq_state_t` enum (`EXEC`/`ISR`/`HALT`);
  - constants `OP_NOP`=8'h00, `OP_HALT`=8'h76, `OP_CB`=8'hCB, `ISR_MCYCLES_DEFAULT`=5.
- One sub-module, `gb_cpu_tcycle_counter`: a parametrised modulo-TCYCLES_PER_M counter with enable and a wrap strobe.

## Test plan
- **Reset release, NOP fetch.** `data_i`=8'h3E, `sched_len_i`=2, 4 `tick_en` → `opcode_o`=8'h3E. Then 8 more ticks pass with `last_mcycle_o` high only in M-cycle 1.
- **CB prefix.** `opcode_o`=8'hCB, `data_i`=8'h37, `irq_i`=`ime_i`=1 → `opcode_o`=8'h37 with `cb_prefix_o`=1, and no ISR. `isr_o`=1 only after the suffix ends.
- **Conditional branch.** Opcode 8'hC2, `sched_len_i`=4, `sched_len_nt_i`=3, `cond_taken_i`=0 → ends after 12 ticks. With `cond_taken_i`=1 → ends after 16 ticks.
- **Interrupt dispatch.** `ime_i`=1, `irq_i`=1 at instruction end → 20 ticks of `isr_o`=1, and `irq_ack_o` pulses once at tick 12. Then `opcode_o`←`data_i`.
- **HALT.**
  - Opcode 8'h76, `irq_i`=0 → `halted_o`=1 with `mcycle_o`=0 indefinitely.
  - `irq_i`=1 with `ime_i`=0 → exits at the next T-wrap and `opcode_o`←`data_i`.
  - Repeat with `ime_i`=1 → enters `ISR`.
- **Async reset mid-instruction.** Assert `reset` at M-cycle 2, T-cycle 1 of a 4-M-cycle op → all outputs return to 0 and `opcode_o`=8'h00 without waiting for a `clk` edge.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types and opcode constants for the gb_cpu sequencing and decode blocks.
// Pure declarations: no logic, no latency, no flow control.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    EXEC = 2'd0,
    ISR  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'h76;
  localparam logic [7:0] OP_CB   = 8'hCB;

  localparam int ISR_MCYCLES_DEFAULT = 5;

endpackage

// File: rtl/gb_cpu_tcycle_counter.sv
// Modulo-MODULUS T-cycle counter; advances on en, wrap is a same-cycle strobe on the last count.
// No backpressure: en low simply freezes the count.
module gb_cpu_tcycle_counter #(
  parameter  int MODULUS = 4,
  localparam int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(MODULUS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/gb_cpu_mcycle_sequencer.sv
// Opcode/CB-prefix holder and T/M-cycle stepper for the decoder schedule; opcode latched on the ending tick, visible next cycle.
// tick_en low freezes all state; the only combinational output is last_mcycle_o.
module gb_cpu_mcycle_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter  int MAX_MCYCLES   = 6,
  parameter  int TCYCLES_PER_M = 4,
  parameter  int ISR_MCYCLES   = ISR_MCYCLES_DEFAULT,
  localparam int CNT_W         = $clog2(MAX_MCYCLES),
  localparam int TC_W          = $clog2(TCYCLES_PER_M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic [7:0]       data_i,
  input  logic [CNT_W:0]   sched_len_i,
  input  logic [CNT_W:0]   sched_len_nt_i,
  input  logic             cond_i,
  input  logic             cond_taken_i,
  input  logic             irq_i,
  input  logic             ime_i,
  output logic [7:0]       opcode_o,
  output logic             cb_prefix_o,
  output logic [CNT_W-1:0] mcycle_o,
  output logic [TC_W-1:0]  tcycle_o,
  output logic             last_mcycle_o,
  output logic             isr_o,
  output logic             halted_o,
  output logic             irq_ack_o
);

  localparam int LEN_W = CNT_W + 1;

  seq_state_t       state_q, state_d;
  logic [7:0]       opcode_d;
  logic             cb_d;
  logic [CNT_W-1:0] mcycle_d;
  logic             ack_q, ack_d;
  logic             t_wrap;
  logic [LEN_W-1:0] len_raw, len_eff;

  gb_cpu_tcycle_counter #(
    .MODULUS (TCYCLES_PER_M)
  ) u_tcycle (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .count (tcycle_o),
    .wrap  (t_wrap)
  );

  // Effective schedule length, clamped into 1..MAX_MCYCLES so the counter can never run away.
  always_comb begin
    len_raw = (cond_i && !cond_taken_i) ? sched_len_nt_i : sched_len_i;
    if (state_q == ISR) begin
      len_eff = LEN_W'(ISR_MCYCLES);
    end else if (len_raw == '0) begin
      len_eff = LEN_W'(1);
    end else if (len_raw > LEN_W'(MAX_MCYCLES)) begin
      len_eff = LEN_W'(MAX_MCYCLES);
    end else begin
      len_eff = len_raw;
    end
    last_mcycle_o = (state_q != HALT) && ({1'b0, mcycle_o} == len_eff - LEN_W'(1));
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_o;
    cb_d     = cb_prefix_o;
    mcycle_d = mcycle_o;
    ack_d    = (state_q == ISR) && (mcycle_o == CNT_W'(2)) && t_wrap;

    if (t_wrap) begin
      if (state_q == HALT) begin
        if (irq_i) begin
          if (ime_i) begin
            state_d = ISR;
          end else begin
            state_d  = EXEC;
            opcode_d = data_i;
            cb_d     = 1'b0;
          end
        end
      end else if (!last_mcycle_o) begin
        mcycle_d = mcycle_o + CNT_W'(1);
      end else begin
        mcycle_d = '0;
        // Prefix and suffix are fetched atomically, so interrupts wait for the suffix.
        if (state_q == EXEC && opcode_o == OP_CB && !cb_prefix_o) begin
          cb_d     = 1'b1;
          opcode_d = data_i;
        end else if (state_q == EXEC && opcode_o == OP_HALT && !cb_prefix_o && !irq_i) begin
          state_d = HALT;
        end else if (state_q == EXEC && ime_i && irq_i) begin
          state_d = ISR;
        end else begin
          state_d  = EXEC;
          opcode_d = data_i;
          cb_d     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EXEC;
      opcode_o    <= OP_NOP;
      cb_prefix_o <= 1'b0;
      mcycle_o    <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_o    <= opcode_d;
      cb_prefix_o <= cb_d;
      mcycle_o    <= mcycle_d;
      ack_q       <= ack_d;
    end
  end

  assign isr_o     = (state_q == ISR);
  assign halted_o  = (state_q == HALT);
  assign irq_ack_o = ack_q;

endmodule

// File: tb/tb_gb_cpu_mcycle_sequencer.sv
// Directed bench for gb_cpu_mcycle_sequencer with a small decoder stand-in and an expectation queue.
module tb_gb_cpu_mcycle_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic [7:0] data_i;
  logic [3:0] sched_len_i, sched_len_nt_i;
  logic       cond_i, cond_taken_i, irq_i, ime_i;
  logic [7:0] opcode_o;
  logic       cb_prefix_o;
  logic [2:0] mcycle_o;
  logic [1:0] tcycle_o;
  logic       last_mcycle_o, isr_o, halted_o, irq_ack_o;

  logic [3:0] dflt_len;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         ticks;
    logic [7:0] op;
    logic       cb;
    logic       isr;
    int         acks;
    int         ack_at;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  gb_cpu_mcycle_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .tick_en        (tick_en),
    .data_i         (data_i),
    .sched_len_i    (sched_len_i),
    .sched_len_nt_i (sched_len_nt_i),
    .cond_i         (cond_i),
    .cond_taken_i   (cond_taken_i),
    .irq_i          (irq_i),
    .ime_i          (ime_i),
    .opcode_o       (opcode_o),
    .cb_prefix_o    (cb_prefix_o),
    .mcycle_o       (mcycle_o),
    .tcycle_o       (tcycle_o),
    .last_mcycle_o  (last_mcycle_o),
    .isr_o          (isr_o),
    .halted_o       (halted_o),
    .irq_ack_o      (irq_ack_o)
  );

  // Decoder stand-in: schedule lengths for the handful of opcodes exercised here.
  always_comb begin
    sched_len_i    = 4'd1;
    sched_len_nt_i = 4'd1;
    cond_i         = 1'b0;
    if (!cb_prefix_o) begin
      case (opcode_o)
        8'h3E, 8'h06: begin sched_len_i = 4'd2; sched_len_nt_i = 4'd2; end
        8'hC2:        begin sched_len_i = 4'd4; sched_len_nt_i = 4'd3; cond_i = 1'b1; end
        8'hC3:        begin sched_len_i = 4'd4; sched_len_nt_i = 4'd4; end
        8'h11:        begin sched_len_i = dflt_len; sched_len_nt_i = dflt_len; end
        default:      ;
      endcase
    end else if (opcode_o == 8'h37) begin
      sched_len_i    = 4'd2;
      sched_len_nt_i = 4'd2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input int ticks, input logic [7:0] op, input logic cb,
                          input logic isr, input int acks, input int ack_at);
    exp_t e;
    e.tag = tag; e.ticks = ticks; e.op = op; e.cb = cb; e.isr = isr; e.acks = acks; e.ack_at = ack_at;
    sb.push_back(e);
  endtask

  // Ticks until the instruction's final T-cycle has been clocked, bounded at 64.
  task automatic run_instr(output int n, output int acks, output int ack_at);
    logic done;
    n = 0; acks = 0; ack_at = 0; done = 1'b0;
    while (!done && n < 64) begin
      done = last_mcycle_o && (tcycle_o == 2'd3);
      tick(1);
      n++;
      if (irq_ack_o) begin
        acks++;
        ack_at = n;
      end
    end
  endtask

  task automatic run_and_score();
    int   n, a, at;
    exp_t e;
    run_instr(n, a, at);
    e = sb.pop_front();
    chk({e.tag, "_ticks"}, n, e.ticks);
    chk({e.tag, "_op"}, opcode_o, e.op);
    chk({e.tag, "_cb"}, cb_prefix_o, e.cb);
    chk({e.tag, "_isr"}, isr_o, e.isr);
    chk({e.tag, "_acks"}, a, e.acks);
    if (e.acks > 0) chk({e.tag, "_ack_at"}, at, e.ack_at);
    chk({e.tag, "_mcyc"}, mcycle_o, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; tick_en = 1'b1; data_i = 8'h00; cond_taken_i = 1'b0;
    irq_i = 1'b0; ime_i = 1'b0; dflt_len = 4'd1;
    #2;
    chk("rst_op", opcode_o, 8'h00);
    chk("rst_cb", cb_prefix_o, 0);
    chk("rst_mcyc", mcycle_o, 0);
    chk("rst_tcyc", tcycle_o, 0);
    chk("rst_isr", isr_o, 0);
    chk("rst_halt", halted_o, 0);
    chk("rst_ack", irq_ack_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset NOP fetches the first opcode.
    data_i = 8'h3E;
    push_exp("nop", 4, 8'h3E, 0, 0, 0, 0);
    run_and_score();

    // Two-M-cycle op: last only in M-cycle 1.
    chk("ld_m0_last", last_mcycle_o, 0);
    tick(4);
    chk("ld_m1", mcycle_o, 1);
    chk("ld_m1_last", last_mcycle_o, 1);
    data_i = 8'hCB;
    push_exp("ld", 4, 8'hCB, 0, 0, 0, 0);
    run_and_score();

    // CB prefix with an interrupt pending: no dispatch until the suffix ends.
    irq_i = 1'b1; ime_i = 1'b1; data_i = 8'h37;
    push_exp("cbpre", 4, 8'h37, 1, 0, 0, 0);
    run_and_score();
    data_i = 8'hAA;
    push_exp("cbsfx", 8, 8'h37, 1, 1, 0, 0);
    run_and_score();

    // Interrupt dispatch: 20 ticks, one ack at tick 12, then fetch.
    irq_i = 1'b0; ime_i = 1'b0; data_i = 8'hC2;
    push_exp("isr", 20, 8'hC2, 0, 0, 1, 12);
    run_and_score();

    // Conditional branch, not taken then taken.
    cond_taken_i = 1'b0; data_i = 8'hC2;
    push_exp("jp_nt", 12, 8'hC2, 0, 0, 0, 0);
    run_and_score();
    cond_taken_i = 1'b1; data_i = 8'h11;
    push_exp("jp_t", 16, 8'h11, 0, 0, 0, 0);
    run_and_score();
    cond_taken_i = 1'b0;

    // Length clamping: 0 runs as 1, 7 runs as MAX_MCYCLES.
    dflt_len = 4'd0; data_i = 8'h11;
    push_exp("len0", 4, 8'h11, 0, 0, 0, 0);
    run_and_score();
    dflt_len = 4'd7; data_i = 8'h76;
    push_exp("lenmax", 24, 8'h76, 0, 0, 0, 0);
    run_and_score();

    // HALT opcode with irq pending at its end: HALT is skipped.
    irq_i = 1'b1; data_i = 8'h3E;
    push_exp("halt_skip", 4, 8'h3E, 0, 0, 0, 0);
    run_and_score();
    chk("halt_skip_h", halted_o, 0);
    irq_i = 1'b0; data_i = 8'h76;
    push_exp("ld_b", 8, 8'h76, 0, 0, 0, 0);
    run_and_score();

    // HALT entry and hold.
    data_i = 8'h00;
    tick(4);
    chk("halt_in", halted_o, 1);
    chk("halt_op", opcode_o, 8'h76);
    tick(10);
    chk("halt_hold", halted_o, 1);
    chk("halt_mcyc", mcycle_o, 0);
    chk("halt_last", last_mcycle_o, 0);
    chk("halt_tcyc", tcycle_o, 2);

    // Wake without IME: exit on the next T-wrap and fetch.
    irq_i = 1'b1; ime_i = 1'b0; data_i = 8'h3E;
    n = 0;
    while (halted_o && n < 16) begin
      tick(1);
      n++;
    end
    chk("wake_ticks", n, 2);
    chk("wake_op", opcode_o, 8'h3E);
    chk("wake_isr", isr_o, 0);

    irq_i = 1'b0; data_i = 8'h76;
    push_exp("ld_c", 8, 8'h76, 0, 0, 0, 0);
    run_and_score();
    tick(4);
    chk("halt2_in", halted_o, 1);
    tick(3);
    irq_i = 1'b1; ime_i = 1'b1;
    tick(1);
    chk("wake_isr_isr", isr_o, 1);
    chk("wake_isr_h", halted_o, 0);
    chk("wake_isr_op", opcode_o, 8'h76);
    irq_i = 1'b0; ime_i = 1'b0; data_i = 8'h00;
    push_exp("isr2", 20, 8'h00, 0, 0, 1, 12);
    run_and_score();

    // tick_en low freezes everything.
    data_i = 8'hC3;
    tick(2);
    tick_en = 1'b0;
    tick(5);
    chk("hold_tcyc", tcycle_o, 2);
    chk("hold_op", opcode_o, 8'h00);
    chk("hold_ack", irq_ack_o, 0);
    tick_en = 1'b1;
    tick(2);
    chk("hold_fetch", opcode_o, 8'hC3);

    // Asynchronous reset in M-cycle 2, T-cycle 1.
    data_i = 8'h06;
    tick(9);
    chk("pre_rst_mcyc", mcycle_o, 2);
    chk("pre_rst_tcyc", tcycle_o, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_op", opcode_o, 8'h00);
    chk("arst_mcyc", mcycle_o, 0);
    chk("arst_tcyc", tcycle_o, 0);
    chk("arst_cb", cb_prefix_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
